inv_sbox_iter: RTL and testbench

Iterative AES inverse S-box unit for the decryption datapath, the inverse of the forward-path affine stage. Each accepted byte goes through the inverse affine transform, then a multiplicative inverse in GF(2^8) computed over 7 clock cycles by repeated squaring. The block sits behind a valid/ready handshake, so an InvSubBytes sequencer can share one instance across all state bytes.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/inv_affine.sv | 15 +
 rtl/inv_sbox_iter.sv | 71 +++++++
 tb/tb_inv_sbox_iter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and the GF(2^8) multiplier.
package aes_pkg;

   localparam logic [7:0] GF_RED       = 8'h1B;
   localparam logic [7:0] INV_AFFINE_C = 8'h05;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1 as the multiplicand shifts out.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = t[7] ? ({t[6:0], 1'b0} ^ GF_RED) : {t[6:0], 1'b0};
      end
      return p;
   endfunction

endpackage

// File: rtl/inv_affine.sv
// AES inverse affine transform; purely combinational.
module inv_affine
   import aes_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] a
);

   always_comb begin
      a = 8'h00;
      for (int i = 0; i < 8; i++)
         a[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ INV_AFFINE_C[i];
   end

endmodule

// File: rtl/inv_sbox_iter.sv
// Iterative AES inverse S-box: inverse affine, then a^254 over 7 square-and-multiply steps.
module inv_sbox_iter
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data
);

   state_t     state, state_nxt;
   logic [2:0] cnt;
   logic [7:0] s, r;
   logic [7:0] a;
   logic [7:0] s2, r_nxt;

   inv_affine u_inv_affine (
      .x (in_data),
      .a (a)
   );

   // s walks a^2, a^4, ..., a^128; r accumulates their product, ending at a^254.
   assign s2    = gf_mul(s, s);
   assign r_nxt = gf_mul(r, s2);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = r;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CALC;
         CALC:    if (cnt == 3'd6) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s   <= 8'h00;
         r   <= 8'h00;
         cnt <= 3'd0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               s   <= a;
               r   <= 8'h01;
               cnt <= 3'd0;
            end
            CALC: begin
               s   <= s2;
               r   <= r_nxt;
               cnt <= cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sbox_iter.sv
// Bench for inv_sbox_iter: S-box tables built from field arithmetic, queue scoreboard, directed + exhaustive runs.
module tb_inv_sbox_iter;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [7:0]  fwd  [256];
   logic [7:0]  invs [256];
   logic [15:0] exp_q [$];   // {input byte, expected result}

   inv_sbox_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] fmul(input logic [7:0] x, input logic [7:0] y);
      int acc = 0;
      int xa  = x;
      int ya  = y;
      while (ya != 0) begin
         if (ya % 2 == 1) acc = acc ^ xa;
         xa = xa * 2;
         if (xa >= 256) xa = xa ^ 'h11B;
         ya = ya / 2;
      end
      return acc[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
      logic [15:0] w;
      w = {v, v} << k;
      return w[15:8];
   endfunction

   // Forward S-box from its definition: field inverse by search, then forward affine.
   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b;
         b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && fmul(x[7:0], y[7:0]) == 8'h01) b = y[7:0];
         fwd[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) invs[fwd[x]] = x[7:0];
   end

   // Scoreboard: push on accept, compare whenever out_valid, pop on consume.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) exp_q.push_back({in_data, invs[in_data]});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               chk("out_data", out_data, exp_q[0][7:0]);
               if (out_ready) begin
                  chk("round_trip", fwd[out_data], exp_q[0][15:8]);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   int acc_cyc;

   // Present a byte until accepted; returns #1 after the accept edge.
   task automatic send(input logic [7:0] b);
      logic acc;
      int   t;
      in_valid = 1'b1;
      in_data  = b;
      t        = 0;
      do begin
         acc = in_ready;
         @(posedge clk); #1;
         t++;
      end while (!acc && t < 50);
      if (!acc) chk("accept_timeout", 0, 1);
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      int first_cyc;
      logic v;

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      rst = 1'b0;

      // pin the reference tables to known AES values
      chk("model_fwd00", fwd[8'h00], 8'h63);
      chk("model_fwd01", fwd[8'h01], 8'h7C);
      chk("model_inv63", invs[8'h63], 8'h00);
      chk("model_inv7C", invs[8'h7C], 8'h01);
      chk("model_invED", invs[8'hED], 8'h53);
      chk("model_inv16", invs[8'h16], 8'hFF);

      // first-result latency: out_valid is sampled high at the 8th edge after accept
      send(8'h63);
      n = 0;
      do begin
         v = out_valid;
         @(posedge clk); #1;
         n++;
      end while (!v && n < 30);
      chk("latency_edges", n, 8);
      drain();

      send(8'h7C); drain();
      send(8'hED); drain();
      send(8'h16); drain();

      // exhaustive, back-to-back, out_ready high
      send(8'h00);
      first_cyc = acc_cyc;
      for (int x = 1; x < 256; x++) send(x[7:0]);
      chk("throughput_cycles", acc_cyc - first_cyc, 255 * 9);
      drain();

      // random bytes with random backpressure
      for (int k = 0; k < 20; k++) begin
         out_ready = $urandom_range(0, 1);
         send($urandom_range(0, 255));
         n = 0;
         while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            out_ready = $urandom_range(0, 1);
            n++;
         end
         out_ready = 1'b1;
         drain();
      end

      // long backpressure in DONE with a competing input
      out_ready = 1'b0;
      send(8'hAB);
      n = 0;
      while (!out_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_reach_done", out_valid, 1);
      in_valid = 1'b1;
      in_data  = 8'h12;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_data", out_data, invs[8'hAB]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("bp_second_accepted", in_ready, 0);
      in_valid = 1'b0;
      drain();

      // reset mid-CALC at cnt==3
      send(8'h10);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 8'h00);
      send(8'h63); drain();

      // reset wins over a simultaneous handshake
      in_valid = 1'b1; in_data = 8'h55; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_vs_accept", in_ready, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("rst_vs_accept_no_out", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
